// File: rtl/seg_time_disp_pkg.sv
// Shared definitions for the 7-segment time display: segment codes, digit count,
// conversion FSM states and the BCD-to-segment lookup.
package seg_time_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Active-low segments, {dp, g, f, e, d, c, b, a}; dp off in every code.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOUR,
    S_MIN,
    S_SEC,
    S_COMMIT
  } state_e;

  function automatic logic [7:0] seg_encode(input logic [3:0] bcd);
    logic [7:0] code;
    case (bcd)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_time_disp_bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to two-digit BCD converter.
// One load cycle then BIN_W shift cycles; done pulses once, digits hold until next start.
module bin2bcd_seq #(
  parameter int unsigned BIN_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] sr_q, sr_d;
  logic [7:0]       bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
  end

  always_comb begin
    sr_d   = sr_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      sr_d   = bin;
      bcd_d  = 8'd0;
      cnt_d  = CntW'(BIN_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
      cnt_d         = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

endmodule

// File: rtl/seg_time_disp.sv
// Six-digit HH MM SS multiplexed 7-segment display with an atomically updated digit buffer.
// Optional SEG_TIME_DISP_COLON_BLINK_EN lights the dp of digits 1 and 3 while committed sec is even.
module seg_time_disp
  import seg_time_disp_pkg::*;
#(
  parameter int unsigned DIGIT_NUM = NUM_DIGITS,
  parameter int unsigned BIN_W     = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [4:0]           hour,
  input  logic [5:0]           min,
  input  logic [5:0]           sec,
  input  logic                 scan_tick,
  output logic [DIGIT_NUM-1:0] sel,
  output logic [7:0]           seg
);

  localparam int unsigned IdxW = $clog2(DIGIT_NUM);

  state_e state_q, state_d;
  logic   go_q, go_d;

  logic [4:0] snap_hour_q, snap_hour_d, last_hour_q, last_hour_d;
  logic [5:0] snap_min_q, snap_min_d, last_min_q, last_min_d;
  logic [5:0] snap_sec_q, snap_sec_d, last_sec_q, last_sec_d;

  logic [DIGIT_NUM-1:0][3:0] stage_q, stage_d;
  logic [DIGIT_NUM-1:0][3:0] disp_q, disp_d;

  logic [IdxW-1:0]      idx_q, idx_d, idx_next;
  logic [DIGIT_NUM-1:0] sel_q, sel_d;
  logic [7:0]           seg_q, seg_d;

  logic             conv_start;
  logic [BIN_W-1:0] conv_bin;
  logic             conv_busy;
  logic             conv_done;
  logic [3:0]       conv_tens;
  logic [3:0]       conv_ones;

  bin2bcd_seq #(
    .BIN_W(BIN_W)
  ) u_bin2bcd (
    .clk  (clk),
    .rstn (rstn),
    .start(conv_start),
    .bin  (conv_bin),
    .busy (conv_busy),
    .done (conv_done),
    .tens (conv_tens),
    .ones (conv_ones)
  );

  // The next field's start is chained onto the previous done to keep commit latency short.
  always_comb begin
    state_d     = state_q;
    go_d        = 1'b0;
    conv_start  = 1'b0;
    conv_bin    = BIN_W'(snap_hour_q);
    snap_hour_d = snap_hour_q;
    snap_min_d  = snap_min_q;
    snap_sec_d  = snap_sec_q;
    last_hour_d = last_hour_q;
    last_min_d  = last_min_q;
    last_sec_d  = last_sec_q;
    stage_d     = stage_q;
    disp_d      = disp_q;
    unique case (state_q)
      S_IDLE: begin
        if (!conv_busy && ({hour, min, sec} != {last_hour_q, last_min_q, last_sec_q})) begin
          snap_hour_d = hour;
          snap_min_d  = min;
          snap_sec_d  = sec;
          go_d        = 1'b1;
          state_d     = S_HOUR;
        end
      end
      S_HOUR: begin
        if (go_q) begin
          conv_start = 1'b1;
        end else if (conv_done) begin
          stage_d[0] = conv_tens;
          stage_d[1] = conv_ones;
          conv_start = 1'b1;
          conv_bin   = BIN_W'(snap_min_q);
          state_d    = S_MIN;
        end
      end
      S_MIN: begin
        if (conv_done) begin
          stage_d[2] = conv_tens;
          stage_d[3] = conv_ones;
          conv_start = 1'b1;
          conv_bin   = BIN_W'(snap_sec_q);
          state_d    = S_SEC;
        end
      end
      S_SEC: begin
        if (conv_done) begin
          stage_d[4] = conv_tens;
          stage_d[5] = conv_ones;
          state_d    = S_COMMIT;
        end
      end
      S_COMMIT: begin
        disp_d      = stage_q;
        last_hour_d = snap_hour_q;
        last_min_d  = snap_min_q;
        last_sec_d  = snap_sec_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan reads disp_q, so a tick on the commit cycle still shows the previous frame.
  always_comb begin
    idx_next = (idx_q == IdxW'(DIGIT_NUM - 1)) ? '0 : idx_q + IdxW'(1);
    idx_d    = idx_q;
    sel_d    = sel_q;
    seg_d    = seg_q;
    if (scan_tick) begin
      idx_d = idx_next;
      sel_d = ~(DIGIT_NUM'(1) << idx_next);
      seg_d = seg_encode(disp_q[idx_next]);
`ifdef SEG_TIME_DISP_COLON_BLINK_EN
      if (((idx_next == IdxW'(1)) || (idx_next == IdxW'(3))) && !disp_q[5][0]) begin
        seg_d[7] = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      go_q        <= 1'b0;
      snap_hour_q <= '0;
      snap_min_q  <= '0;
      snap_sec_q  <= '0;
      last_hour_q <= '0;
      last_min_q  <= '0;
      last_sec_q  <= '0;
      stage_q     <= '0;
      disp_q      <= '0;
      idx_q       <= '0;
      sel_q       <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      snap_hour_q <= snap_hour_d;
      snap_min_q  <= snap_min_d;
      snap_sec_q  <= snap_sec_d;
      last_hour_q <= last_hour_d;
      last_min_q  <= last_min_d;
      last_sec_q  <= last_sec_d;
      stage_q     <= stage_d;
      disp_q      <= disp_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_time_disp.sv
// Scoreboard bench for seg_time_disp: ticks push expected sel/seg, a monitor pops and compares.
module tb_seg_time_disp;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       scan_tick;
  logic [5:0] sel;
  logic [7:0] seg;

  int n_vec = 0;
  int n_err = 0;

  int m_h, m_m, m_s, m_idx;
  logic [13:0] exp_q[$];

  seg_time_disp dut (
    .clk      (clk),
    .rstn     (rstn),
    .hour     (hour),
    .min      (min),
    .sec      (sec),
    .scan_tick(scan_tick),
    .sel      (sel),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_code(int d);
    logic [7:0] tab [10];
    tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tab[d];
  endfunction

  // Expected {sel, seg} for a digit position showing the time h:m:s.
  function automatic logic [13:0] ref_out(int idx, int h, int m, int s);
    int         d;
    logic [5:0] one;
    logic [7:0] code;
    one = 6'd1;
    case (idx)
      0:       d = h / 10;
      1:       d = h % 10;
      2:       d = m / 10;
      3:       d = m % 10;
      4:       d = s / 10;
      default: d = s % 10;
    endcase
    code = ref_code(d);
`ifdef SEG_TIME_DISP_COLON_BLINK_EN
    if ((idx == 1 || idx == 3) && (s % 2 == 0)) code[7] = 1'b0;
`endif
    return {~(one << idx), code};
  endfunction

  task automatic check8(string name, logic [7:0] act, logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    scan_tick = 1'b1;
    m_idx = (m_idx + 1) % 6;
    exp_q.push_back(ref_out(m_idx, m_h, m_m, m_s));
    @(negedge clk);
    scan_tick = 1'b0;
  endtask

  task automatic apply(int h, int m, int s, int wait_cyc);
    @(negedge clk);
    hour = 5'(h);
    min  = 6'(m);
    sec  = 6'(s);
    m_h = h;
    m_m = m;
    m_s = s;
    repeat (wait_cyc) @(posedge clk);
  endtask

  // Monitor: outputs are defined one cycle after each sampled tick.
  initial begin
    logic        hit;
    logic [13:0] req;
    forever begin
      @(posedge clk);
      hit = scan_tick && rstn;
      @(negedge clk);
      if (hit) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scan_unexpected got sel=%h seg=%h required=no output", sel, seg);
        end else begin
          req = exp_q.pop_front();
          if ({sel, seg} !== req) begin
            n_err++;
            $display("FAIL scan_out got sel=%h seg=%h required sel=%h seg=%h",
                     sel, seg, req[13:8], req[7:0]);
          end
        end
      end
    end
  end

  initial begin
    int n;
    rstn = 1'b0;
    scan_tick = 1'b0;
    hour = 5'd12;
    min = 6'd34;
    sec = 6'd56;
    m_h = 0;
    m_m = 0;
    m_s = 0;
    m_idx = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    // Buffer still zero while hour=12 is being converted.
    do_tick();
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check8("reset_async_sel", {2'b00, sel}, 8'h3F);
    check8("reset_async_seg", seg, 8'hFF);
    hour = 5'd0;
    min = 6'd0;
    sec = 6'd0;
    m_idx = 0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check8("blank_before_tick_sel", {2'b00, sel}, 8'h3F);
    check8("blank_before_tick_seg", seg, 8'hFF);
    do_tick();

    apply(12, 34, 56, 30);
    while (m_idx != 5) do_tick();
    repeat (7) do_tick();

    // Commit latency: tick lands on digit 5 just after the allowed window.
    while (m_idx != 4) do_tick();
    apply(12, 34, 57, 25);
    repeat (6) do_tick();

    apply(12, 34, 58, 2);
    apply(12, 34, 59, 60);
    repeat (6) do_tick();

    apply(23, 59, 59, 30);
    repeat (6) do_tick();
    while (m_idx != 5) do_tick();
    apply(0, 0, 0, 25);
    repeat (6) do_tick();

    apply(12, 34, 58, 30);
    repeat (6) do_tick();
    apply(31, 63, 63, 30);
    repeat (6) do_tick();

    for (int it = 0; it < 40; it++) begin
      apply(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 63)), 25 + int'($urandom_range(0, 6)));
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_tick();
      end
    end

    repeat (4) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
